// File: rtl/jtag_dtm_pkg.sv
// jtag_dtm_pkg: TAP state encoding, IR codes and DMI constants shared by the DTM and debug module
package jtag_defs;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS = 5'h10;
  localparam logic [4:0] IR_DMI = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;
  localparam logic [31:0] DTMCS_VALUE = 32'h0000_5061;
  localparam logic [31:0] IDCODE_DEFAULT = 32'h1e20_0a6d;
  localparam int DMI_ADDR_W = 6;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_OP_W = 2;
  localparam logic [1:0] DTM_OP_NOP = 2'b00;
  localparam logic [1:0] DTM_OP_READ = 2'b01;
  localparam logic [1:0] DTM_OP_WRITE = 2'b10;
endpackage

// File: rtl/jtag_dtm_if.sv
// jtag_dtm_if: DMI request/response link between the DTM (master) and debug module (slave)
interface jtag_dtm_if #(parameter int DTM_REQ_BITS = 40);
  logic                    dtm_req_valid;
  logic [DTM_REQ_BITS-1:0] dtm_req_data;
  logic                    dm_is_busy;
  logic [DTM_REQ_BITS-1:0] dm_resp_data;
  modport master(output dtm_req_valid, dtm_req_data, input dm_is_busy, dm_resp_data);
  modport slave(input dtm_req_valid, dtm_req_data, output dm_is_busy, dm_resp_data);
endinterface

// File: rtl/jtag_dtm_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 16-state TAP controller driven by TMS
module jtag_tap_fsm
  import jtag_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_t state
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= TEST_LOGIC_RESET;
    else
      case (state)
        TEST_LOGIC_RESET: state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        state <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         state <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         state <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         state <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         state <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         state <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         state <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
endmodule

// File: rtl/jtag_dtm.sv
// jtag_dtm: RISC-V JTAG debug transport module with IDCODE, DTMCS, DMI and BYPASS registers
module jtag_dtm
  import jtag_defs::*;
#(
  parameter int          DMI_ADDR_BITS = 6,
  parameter int          DMI_DATA_BITS = 32,
  parameter int          DMI_OP_BITS = 2,
  parameter int          DTM_REQ_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jtag_TMS,
  input  logic        jtag_TDI,
  output logic        jtag_TDO,
  jtag_dtm_if.master  dmi
);
  tap_state_t              state;
  logic [4:0]              ir, ir_sr, sel;
  logic [DTM_REQ_BITS-1:0] dr, cap_val, shift_val;
  logic [DMI_OP_BITS-1:0]  op, status;
  logic                    sticky, op_fwd;
  jtag_tap_fsm u_fsm (.clk(clk), .rst_n(rst_n), .tms(jtag_TMS), .state(state));
  always_comb begin
    sel = (ir == IR_IDCODE || ir == IR_DTMCS || ir == IR_DMI) ? ir : IR_BYPASS;
    status = (sticky || dmi.dm_is_busy) ? '1 : '0;
    op = dr[DMI_OP_BITS-1:0];
    op_fwd = op == DMI_OP_BITS'(DTM_OP_READ) || op == DMI_OP_BITS'(DTM_OP_WRITE);
    cap_val = sel == IR_IDCODE ? DTM_REQ_BITS'(IDCODE_VALUE) :
              sel == IR_DTMCS  ? DTM_REQ_BITS'(DTMCS_VALUE | {20'd0, sticky, sticky, 10'd0}) :
              sel == IR_DMI    ? {dmi.dm_resp_data[DTM_REQ_BITS-1:DMI_OP_BITS], status} : '0;
    // TDI enters at the top of the active length: 40 for DMI, 1 for BYPASS, 32 otherwise
    shift_val = sel == IR_DMI    ? {jtag_TDI, dr[DTM_REQ_BITS-1:1]} :
                sel == IR_BYPASS ? {dr[DTM_REQ_BITS-1:1], jtag_TDI} :
                                   {dr[DTM_REQ_BITS-1:32], jtag_TDI, dr[31:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir <= IR_IDCODE;
      ir_sr <= '0;
      dr <= '0;
      sticky <= 1'b0;
      dmi.dtm_req_valid <= 1'b0;
      dmi.dtm_req_data <= '0;
    end else begin
      dmi.dtm_req_valid <= 1'b0;
      case (state)
        TEST_LOGIC_RESET: begin
          ir <= IR_IDCODE;
          sticky <= 1'b0;
        end
        CAPTURE_IR: ir_sr <= 5'b00001;
        SHIFT_IR:   ir_sr <= {jtag_TDI, ir_sr[4:1]};
        UPDATE_IR:  ir <= ir_sr;
        CAPTURE_DR: dr <= cap_val;
        SHIFT_DR:   dr <= shift_val;
        UPDATE_DR:
          if (sel == IR_DMI && op_fwd) begin
            if (sticky || dmi.dm_is_busy) sticky <= 1'b1;
            else begin
              dmi.dtm_req_valid <= 1'b1;
              dmi.dtm_req_data <= dr;
            end
          end else if (sel == IR_DTMCS && (dr[16] || dr[17])) sticky <= 1'b0;
        default: ;
      endcase
    end
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) jtag_TDO <= 1'b0;
    else jtag_TDO <= state == SHIFT_DR ? dr[0] : state == SHIFT_IR ? ir_sr[0] : 1'b0;
endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: randomized scoreboard bench for jtag_dtm against a register-level reference model
module tb_jtag_dtm;
  import jtag_defs::*;
  logic clk = 0, rst_n = 0, tms = 1, tdi = 0;
  logic tdo;
  jtag_dtm_if dmi();
  jtag_dtm dut (.clk(clk), .rst_n(rst_n), .jtag_TMS(tms), .jtag_TDI(tdi), .jtag_TDO(tdo), .dmi(dmi));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [39:0] act;
    logic [39:0] exp;
  } cmp_t;
  cmp_t cmp_q[$];
  logic [39:0] exp_req[$];
  int checks = 0, errors = 0;
  logic [4:0] m_ir;
  bit m_sticky;
  logic [39:0] m_last_req;
  // Monitor: every strobe consumes one predicted request; queued observations are scored here too
  always @(negedge clk) begin
    cmp_t c;
    logic [39:0] e;
    if (dmi.dtm_req_valid === 1'b1) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL req_strobe got %h expected no request", dmi.dtm_req_data);
      end else begin
        e = exp_req.pop_front();
        if (dmi.dtm_req_data !== e) begin
          errors++;
          $display("FAIL req_strobe_data got %h expected %h", dmi.dtm_req_data, e);
        end
      end
    end
    while (cmp_q.size() > 0) begin
      c = cmp_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s got %h expected %h", c.name, c.act, c.exp);
      end
    end
  end
  task automatic push(input string n, input logic [39:0] a, input logic [39:0] e);
    cmp_q.push_back('{n, a, e});
  endtask
  function automatic logic [4:0] eff(input logic [4:0] v);
    return (v == 5'h01 || v == 5'h10 || v == 5'h11) ? v : 5'h1f;
  endfunction
  task automatic tick(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    @(negedge clk);
    #1 o = tdo;
    @(posedge clk);
    #1;
  endtask
  task automatic go_reset();
    logic o;
    repeat (5) tick(1, 0, o);
    tick(0, 0, o);
    m_ir = 5'h01;
    m_sticky = 0;
  endtask
  task automatic ir_scan(input logic [4:0] v);
    logic o;
    logic [39:0] got = '0;
    tick(1, 0, o);
    tick(1, 0, o);
    tick(0, 0, o);
    tick(0, 0, o);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, v[i], o);
      got[i] = o;
    end
    tick(1, 0, o);
    tick(0, 0, o);
    push("ir_capture", got, 40'h1);
    m_ir = v;
  endtask
  task automatic dr_scan(input logic [39:0] din, input bit busy, input int blen);
    logic o;
    logic [39:0] got = '0, exp_cap, exp_out, mask;
    logic [4:0] s = eff(m_ir);
    int len = s == 5'h11 ? 40 : s == 5'h1f ? blen : 32;
    bit req = 0;
    mask = len == 40 ? '1 : (40'h1 << len) - 1;
    case (s)
      5'h01:   exp_cap = 40'h1e200a6d;
      5'h10:   exp_cap = 40'h5061 | (m_sticky ? 40'hc00 : 40'h0);
      5'h11:   exp_cap = {dmi.dm_resp_data[39:2], (m_sticky || busy) ? 2'b11 : 2'b00};
      default: exp_cap = 40'h0;
    endcase
    exp_out = s == 5'h1f ? (din << 1) & mask : exp_cap & mask;
    dmi.dm_is_busy = busy;
    tick(1, 0, o);
    tick(0, 0, o);
    tick(0, 0, o);
    for (int i = 0; i < len; i++) begin
      tick(i == len - 1, din[i], o);
      got[i] = o;
    end
    tick(1, 0, o);
    tick(0, 0, o);
    dmi.dm_is_busy = 0;
    if (s == 5'h11 && (din[1:0] == 2'b01 || din[1:0] == 2'b10)) begin
      if (m_sticky || busy) m_sticky = 1;
      else begin
        req = 1;
        exp_req.push_back(din);
        m_last_req = din;
      end
    end else if (s == 5'h10 && (din[16] || din[17])) m_sticky = 0;
    push("dr_capture", got, exp_out);
    push("req_valid", {39'd0, dmi.dtm_req_valid}, {39'd0, req});
    if (req) push("req_data", dmi.dtm_req_data, din);
    tick(0, 0, o);
    push("req_pulse_end", {39'd0, dmi.dtm_req_valid}, 40'd0);
    push("tdo_idle", {39'd0, o}, 40'd0);
  endtask
  initial begin
    logic o;
    logic [4:0] codes [5];
    dmi.dm_is_busy = 0;
    dmi.dm_resp_data = '0;
    m_ir = 5'h01;
    m_sticky = 0;
    m_last_req = '0;
    #3;
    push("reset_tdo", {39'd0, tdo}, 40'd0);
    push("reset_valid", {39'd0, dmi.dtm_req_valid}, 40'd0);
    push("reset_data", dmi.dtm_req_data, 40'd0);
    #9 rst_n = 1;
    @(posedge clk);
    #1;
    go_reset();
    dr_scan(40'h0, 0, 1);
    ir_scan(5'h10);
    dr_scan(40'h0, 0, 1);
    ir_scan(5'h11);
    dr_scan(40'h4000000006, 0, 1);
    dr_scan({6'h11, 32'h0, 2'b01}, 0, 1);
    dmi.dm_resp_data = {6'h11, 32'h00400982, 2'b00};
    dr_scan(40'h0, 0, 1);
    dr_scan({6'h12, 32'hdeadbeef, 2'b10}, 1, 1);
    dr_scan(40'h0, 0, 1);
    ir_scan(5'h10);
    dr_scan(40'h00010000, 0, 1);
    ir_scan(5'h11);
    dr_scan(40'h0, 0, 1);
    ir_scan(5'h1f);
    dr_scan({$urandom, $urandom}, 0, 20);
    ir_scan(5'h07);
    dr_scan({$urandom, $urandom}, 0, 9);
    go_reset();
    push("tlr_keeps_req_data", dmi.dtm_req_data, m_last_req);
    dr_scan(40'h0, 0, 1);
    codes = '{5'h01, 5'h10, 5'h11, 5'h1f, 5'h00};
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: ir_scan($urandom_range(0, 4) == 4 ? 5'($urandom) : codes[$urandom_range(0, 3)]);
        1: go_reset();
        2: dmi.dm_resp_data = {$urandom, $urandom};
        default: dr_scan({$urandom, $urandom}, $urandom_range(0, 3) == 0, $urandom_range(1, 40));
      endcase
    end
    go_reset();
    ir_scan(5'h11);
    dr_scan({6'h05, 32'h12345678, 2'b10}, 0, 1);
    tick(1, 0, o);
    tick(0, 0, o);
    tick(0, 0, o);
    repeat (7) tick(0, 1, o);
    rst_n = 0;
    #2;
    push("midscan_tdo", {39'd0, tdo}, 40'd0);
    push("midscan_valid", {39'd0, dmi.dtm_req_valid}, 40'd0);
    push("midscan_data", dmi.dtm_req_data, 40'd0);
    rst_n = 1;
    m_last_req = '0;
    @(posedge clk);
    #1;
    go_reset();
    dr_scan(40'h0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    push("pending_requests", 40'(exp_req.size()), 40'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
